// File: rtl/rand_pkg.sv
// Shared types and widths for the bounded-random reader and its helpers.
package rand_pkg;

  localparam int RAND_W = 8;
  localparam int ATT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : rand_pkg

// File: rtl/range_mask.sv
// Combinational mask generator: smallest 2^k-1 covering limit-1, used for
// mask-and-reject sampling of a random word into [0, limit).
module range_mask #(
  parameter int W = 8
) (
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] mask_o
);

  logic [W-1:0] smear;

  always_comb begin
    smear = limit_i - W'(1);
    for (int sh = 1; sh < W; sh = sh * 2) begin
      smear = smear | (smear >> sh);
    end
    mask_o = smear;
  end

endmodule : range_mask

// File: rtl/rand_range_reader.sv
// Pulls bytes from the random holding register and reduces each into
// [0, limit) by mask-and-reject, with a bounded retry count and fallback.
module rand_range_reader
  import rand_pkg::*;
#(
  parameter int MAX_TRIES = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [RAND_W-1:0] rand_byte,
  output logic              reg_en,
  input  logic              req,
  input  logic [RAND_W-1:0] limit,
  output logic              valid,
  output logic [RAND_W-1:0] value,
  input  logic              ack,
  output logic              err,
  output logic              fallback,
  output logic              busy
);

  localparam logic [ATT_W-1:0] LAST_TRY = ATT_W'(MAX_TRIES - 1);

  state_e            state_q, state_d;
  logic [RAND_W-1:0] limit_q, limit_d;
  logic [RAND_W-1:0] value_q, value_d;
  logic              err_q, err_d;
  logic              fallback_q, fallback_d;
  logic [ATT_W-1:0]  attempt_q, attempt_d;

  logic [RAND_W-1:0] mask;
  logic [RAND_W-1:0] masked;

  range_mask #(.W(RAND_W)) u_range_mask (
    .limit_i (limit_q),
    .mask_o  (mask)
  );

  assign masked = rand_byte & mask;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    limit_d    = limit_q;
    value_d    = value_q;
    err_d      = err_q;
    fallback_d = fallback_q;
    attempt_d  = attempt_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (limit != '0) begin
            limit_d   = limit;
            attempt_d = '0;
            state_d   = LOAD;
          end else begin
            value_d    = '0;
            err_d      = 1'b1;
            fallback_d = 1'b0;
            state_d    = DONE;
          end
        end
      end

      LOAD: state_d = CHECK;

      CHECK: begin
        if (masked < limit_q) begin
          value_d    = masked;
          err_d      = 1'b0;
          fallback_d = 1'b0;
          state_d    = DONE;
        end else if (attempt_q == LAST_TRY) begin
          // mask <= 2*limit-1 keeps this difference inside [0, limit).
          value_d    = masked - limit_q;
          err_d      = 1'b0;
          fallback_d = 1'b1;
          state_d    = DONE;
        end else begin
          attempt_d = attempt_q + ATT_W'(1);
          state_d   = LOAD;
        end
      end

      DONE: begin
        if (ack) begin
          err_d      = 1'b0;
          fallback_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      value_q    <= '0;
      err_q      <= 1'b0;
      fallback_q <= 1'b0;
      attempt_q  <= '0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      value_q    <= value_d;
      err_q      <= err_d;
      fallback_q <= fallback_d;
      attempt_q  <= attempt_d;
    end
  end

  // Decoded straight from state so clr drops them without waiting for an edge.
  assign reg_en   = (state_q == LOAD);
  assign valid    = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign value    = value_q;
  assign err      = err_q;
  assign fallback = fallback_q;

endmodule : rand_range_reader

// File: tb/tb_rand_range_reader.sv
// Directed scoreboard bench for rand_range_reader with a modelled holding register.
module tb_rand_range_reader;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] rand_byte;
  logic       reg_en;
  logic       req;
  logic [7:0] limit;
  logic       valid;
  logic [7:0] value;
  logic       ack;
  logic       err;
  logic       fallback;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [7:0] byte_q[$];

  typedef struct {
    logic [7:0] value;
    logic       err;
    logic       fb;
    int         n_pulse;
    int         lat;
  } exp_t;

  exp_t sb[$];

  rand_range_reader #(.MAX_TRIES(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .rand_byte (rand_byte),
    .reg_en    (reg_en),
    .req       (req),
    .limit     (limit),
    .valid     (valid),
    .value     (value),
    .ack       (ack),
    .err       (err),
    .fallback  (fallback),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Holding register model: captures the next queued byte when reg_en pulses.
  always @(posedge clk) begin
    if (reg_en) begin
      pulses <= pulses + 1;
      if (byte_q.size() != 0) rand_byte <= byte_q.pop_front();
      else                    rand_byte <= 8'h00;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [7:0] lim, input logic [7:0] v, input logic e,
                         input logic f, input int np, input int lat, input int hold);
    exp_t x;
    int   p0;
    int   n;
    logic [7:0] v_hold;
    logic e_hold, f_hold;
    x = '{value: v, err: e, fb: f, n_pulse: np, lat: lat};
    sb.push_back(x);
    @(negedge clk);
    req   = 1'b1;
    limit = lim;
    p0    = pulses;
    @(negedge clk);
    req   = 1'b0;
    limit = 8'h5A;
    n     = 1;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    x = sb.pop_front();
    check("valid_seen", 32'(valid), 32'd1);
    check("latency", n, x.lat);
    check("value", 32'(value), 32'(x.value));
    check("err", 32'(err), 32'(x.err));
    check("fallback", 32'(fallback), 32'(x.fb));
    check("reg_en_pulses", pulses - p0, x.n_pulse);
    v_hold = value;
    e_hold = err;
    f_hold = fallback;
    for (int i = 0; i < hold; i++) begin
      req   = i[0];
      limit = 8'(i * 7);
      @(negedge clk);
    end
    if (hold > 0) begin
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_value", 32'(value), 32'(v_hold));
      check("hold_err", 32'(err), 32'(e_hold));
      check("hold_fallback", 32'(fallback), 32'(f_hold));
      check("hold_pulses", pulses - p0, x.n_pulse);
    end
    ack = 1'b1;
    req = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    req = 1'b0;
    check("ack_busy", 32'(busy), 32'd0);
    check("ack_valid", 32'(valid), 32'd0);
    check("ack_flags", {30'd0, err, fallback}, 32'd0);
    @(negedge clk);
    check("req_with_ack_ignored", {30'd0, busy, reg_en}, 32'd0);
  endtask

  initial begin
    clr       = 1'b1;
    req       = 1'b0;
    ack       = 1'b0;
    limit     = 8'h00;
    rand_byte = 8'h00;
    #12;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_reg_en", 32'(reg_en), 32'd0);
    check("rst_flags", {30'd0, err, fallback}, 32'd0);
    check("rst_value", 32'(value), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    byte_q = '{8'h27};
    request(8'd10, 8'd7, 1'b0, 1'b0, 1, 3, 0);

    byte_q = '{8'h3C, 8'h25};
    request(8'd10, 8'd5, 1'b0, 1'b0, 2, 5, 0);

    byte_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    request(8'd10, 8'd5, 1'b0, 1'b1, 4, 9, 0);
    byte_q.delete();

    request(8'd0, 8'd0, 1'b1, 1'b0, 0, 1, 0);

    byte_q = '{8'hAB};
    request(8'd1, 8'd0, 1'b0, 1'b0, 1, 3, 0);

    byte_q = '{8'hFF, 8'h10};
    request(8'd255, 8'h10, 1'b0, 1'b0, 2, 5, 0);

    byte_q = '{8'hC5};
    request(8'd128, 8'h45, 1'b0, 1'b0, 1, 3, 20);

    // Asynchronous clear while the FSM sits in CHECK.
    byte_q = '{8'h27};
    @(negedge clk);
    req   = 1'b1;
    limit = 8'd10;
    @(negedge clk);
    req = 1'b0;
    check("mid_load_reg_en", 32'(reg_en), 32'd1);
    @(negedge clk);
    check("mid_check_busy", 32'(busy), 32'd1);
    #2 clr = 1'b1;
    #1;
    check("clr_reg_en", 32'(reg_en), 32'd0);
    check("clr_valid", 32'(valid), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_value", 32'(value), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    byte_q.delete();
    @(negedge clk);
    check("post_clr_idle", {30'd0, busy, valid}, 32'd0);

    byte_q = '{8'h06};
    request(8'd3, 8'd2, 1'b0, 1'b0, 1, 3, 0);

    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rand_range_reader
